hazard_sequencer: RTL and testbench

Pipeline hazard controller for the 5-stage core. It sits beside the forwarding unit and decides when forwarding cannot cover a dependency. It sequences stalls, bubbles and flushes for IF/ID/EX/MEM across four cases: load-use and ID-consumed operand hazards, data-memory wait, multi-cycle MDU ops, and branch/trap redirects. It also keeps a saturating stall-cycle counter for performance monitoring.

---
 rtl/hazard_sequencer_if.sv | 76 +++++++
 rtl/hazard_sequencer.sv | 211 +++++++++++++++++++++
 tb/tb_hazard_sequencer.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_sequencer_if.sv
// Hazard sequencer bundle: the pipeline hazard inputs and the stage control
// outputs of hazard_sequencer, grouped so the core and the bench share one
// definition.
//
// Inputs to the sequencer (driven by the pipeline, "master" side):
//   id_rs1/id_rs2/id_fwd_type            : operand info of the ID instruction
//   ex_reg_we/ex_rd/ex_mem_read          : EX stage writer info
//   mem_reg_we/mem_rd/mem_mem_read       : MEM stage writer info
//   mem_req/mem_ack                      : data-memory access handshake
//   mdu_busy                             : multi-cycle MDU op still running
//   branch_taken/trap                    : one-cycle redirect pulses
//   clear_stats                          : synchronous clear of stall_cycles
// Outputs from the sequencer ("slave" side):
//   stall_if/id/ex/mem                   : hold stage registers
//   bubble_ex/mem/wb                     : insert NOP into ID/EX, EX/MEM, MEM/WB
//   flush_id/ex/mem                      : kill stage contents
//   stall_cycles                         : saturating count of stall_if cycles
//   dbgState                             : current FSM state, for observation
//
// Handshake: mem_req is held high by the MEM stage while an access is
// outstanding; the access completes in the cycle mem_ack is high. There is no
// ready/backpressure on the control outputs: they act in the cycle asserted.
interface hazard_sequencer_if #(
    parameter int CNT_WIDTH = 16
);
    logic [4:0]           id_rs1;
    logic [4:0]           id_rs2;
    logic [1:0]           id_fwd_type;
    logic                 ex_reg_we;
    logic [4:0]           ex_rd;
    logic                 ex_mem_read;
    logic                 mem_reg_we;
    logic [4:0]           mem_rd;
    logic                 mem_mem_read;
    logic                 mem_req;
    logic                 mem_ack;
    logic                 mdu_busy;
    logic                 branch_taken;
    logic                 trap;
    logic                 clear_stats;

    logic                 stall_if;
    logic                 stall_id;
    logic                 stall_ex;
    logic                 stall_mem;
    logic                 bubble_ex;
    logic                 bubble_mem;
    logic                 bubble_wb;
    logic                 flush_id;
    logic                 flush_ex;
    logic                 flush_mem;
    logic [CNT_WIDTH-1:0] stall_cycles;
    logic [1:0]           dbgState;

    modport master (
        output id_rs1, id_rs2, id_fwd_type,
        output ex_reg_we, ex_rd, ex_mem_read,
        output mem_reg_we, mem_rd, mem_mem_read,
        output mem_req, mem_ack, mdu_busy, branch_taken, trap, clear_stats,
        input  stall_if, stall_id, stall_ex, stall_mem,
        input  bubble_ex, bubble_mem, bubble_wb,
        input  flush_id, flush_ex, flush_mem,
        input  stall_cycles, dbgState
    );

    modport slave (
        input  id_rs1, id_rs2, id_fwd_type,
        input  ex_reg_we, ex_rd, ex_mem_read,
        input  mem_reg_we, mem_rd, mem_mem_read,
        input  mem_req, mem_ack, mdu_busy, branch_taken, trap, clear_stats,
        output stall_if, stall_id, stall_ex, stall_mem,
        output bubble_ex, bubble_mem, bubble_wb,
        output flush_id, flush_ex, flush_mem,
        output stall_cycles, dbgState
    );
endinterface

// File: rtl/hazard_sequencer.sv
// Pipeline hazard controller for the 5-stage core. Decides when forwarding
// cannot cover a dependency and sequences stalls, bubbles and flushes for
// load-use / ID-operand hazards, data-memory waits, multi-cycle MDU ops and
// branch/trap redirects. Keeps a saturating stall-cycle counter.
//
// Ports:
//   clock    : core clock
//   reset_n  : asynchronous active-low reset
//   hz       : hazard_sequencer_if.slave bundle (see interface header)
module hazard_sequencer #(
    parameter int CNT_WIDTH = 16
) (
    input logic               clock,
    input logic               reset_n,
    hazard_sequencer_if.slave hz
);
    typedef enum logic [1:0] {
        RUN       = 2'd0,
        HAZ_STALL = 2'd1,
        MEM_WAIT  = 2'd2,
        MDU_WAIT  = 2'd3
    } seqState_e;

    // forwarding_type_t encoding
    localparam logic [1:0] FT_NONE  = 2'd0;
    localparam logic [1:0] FT_TYPE1 = 2'd1;
    localparam logic [1:0] FT_TYPE2 = 2'd2;
    localparam logic [1:0] FT_TYPE13 = 2'd3;

    seqState_e state, nextState;
    logic [1:0] hazCnt, nextCnt;
    logic       pendBranch, nextPendBranch;
    logic       pendTrap, nextPendTrap;

    logic stallIf, stallId, stallEx, stallMem;
    logic bubbleEx, bubbleMem, bubbleWb;
    logic flushId, flushEx, flushMem;

    logic needId1, needId2, needEx1, needEx2;
    logic [1:0] costId1, costId2, costEx1, costEx2, hazN;
    logic redirect;

    // Stall cost for an operand read in ID. x0 never matches.
    function automatic logic [1:0] idCost(input logic [4:0] r,
                                          input logic exWe, input logic exLd,
                                          input logic [4:0] exRd,
                                          input logic memWe, input logic memLd,
                                          input logic [4:0] memRd);
        if (r == 5'd0)                          return 2'd0;
        if (exWe && exLd && exRd == r)          return 2'd2;
        if (exWe && exRd == r)                  return 2'd1;
        if (memWe && memLd && memRd == r)       return 2'd1;
        return 2'd0;
    endfunction

    // Stall cost for an operand read in EX: only an EX load cannot be forwarded.
    function automatic logic [1:0] exCost(input logic [4:0] r,
                                          input logic exWe, input logic exLd,
                                          input logic [4:0] exRd);
        if (r != 5'd0 && exWe && exLd && exRd == r) return 2'd1;
        return 2'd0;
    endfunction

    function automatic logic [1:0] max2(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

    always_comb begin
        needId1 = (hz.id_fwd_type == FT_TYPE1) || (hz.id_fwd_type == FT_TYPE13);
        needId2 = (hz.id_fwd_type == FT_TYPE1);
        needEx1 = (hz.id_fwd_type == FT_TYPE2);
        needEx2 = (hz.id_fwd_type == FT_TYPE2) || (hz.id_fwd_type == FT_TYPE13);
        costId1 = needId1 ? idCost(hz.id_rs1, hz.ex_reg_we, hz.ex_mem_read, hz.ex_rd,
                                   hz.mem_reg_we, hz.mem_mem_read, hz.mem_rd) : 2'd0;
        costId2 = needId2 ? idCost(hz.id_rs2, hz.ex_reg_we, hz.ex_mem_read, hz.ex_rd,
                                   hz.mem_reg_we, hz.mem_mem_read, hz.mem_rd) : 2'd0;
        costEx1 = needEx1 ? exCost(hz.id_rs1, hz.ex_reg_we, hz.ex_mem_read, hz.ex_rd) : 2'd0;
        costEx2 = needEx2 ? exCost(hz.id_rs2, hz.ex_reg_we, hz.ex_mem_read, hz.ex_rd) : 2'd0;
        hazN    = max2(max2(costId1, costId2), max2(costEx1, costEx2));
    end

    assign redirect = hz.branch_taken | hz.trap;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= RUN;
            hazCnt     <= 2'd0;
            pendBranch <= 1'b0;
            pendTrap   <= 1'b0;
        end else begin
            state      <= nextState;
            hazCnt     <= nextCnt;
            pendBranch <= nextPendBranch;
            pendTrap   <= nextPendTrap;
        end
    end

    always_comb begin
        nextState      = state;
        nextCnt        = hazCnt;
        nextPendBranch = pendBranch;
        nextPendTrap   = pendTrap;
        stallIf   = 1'b0;
        stallId   = 1'b0;
        stallEx   = 1'b0;
        stallMem  = 1'b0;
        bubbleEx  = 1'b0;
        bubbleMem = 1'b0;
        bubbleWb  = 1'b0;
        flushId   = 1'b0;
        flushEx   = 1'b0;
        flushMem  = 1'b0;

        unique case (state)
            RUN: begin
                // A flush deferred from a wait is issued together with any new pulse.
                if (redirect || pendBranch || pendTrap) begin
                    flushId        = 1'b1;
                    flushEx        = 1'b1;
                    flushMem       = hz.trap | pendTrap;
                    nextPendBranch = 1'b0;
                    nextPendTrap   = 1'b0;
                end else if (hz.mem_req && !hz.mem_ack) begin
                    stallIf   = 1'b1;
                    stallId   = 1'b1;
                    stallEx   = 1'b1;
                    stallMem  = 1'b1;
                    bubbleWb  = 1'b1;
                    nextState = MEM_WAIT;
                end else if (hz.mdu_busy) begin
                    stallIf   = 1'b1;
                    stallId   = 1'b1;
                    stallEx   = 1'b1;
                    bubbleMem = 1'b1;
                    nextState = MDU_WAIT;
                end else if (hazN != 2'd0) begin
                    stallIf  = 1'b1;
                    stallId  = 1'b1;
                    bubbleEx = 1'b1;
                    nextCnt  = hazN - 2'd1;
                    if (hazN > 2'd1) nextState = HAZ_STALL;
                end
            end
            HAZ_STALL: begin
                if (redirect) begin
                    flushId   = 1'b1;
                    flushEx   = 1'b1;
                    flushMem  = hz.trap;
                    nextCnt   = 2'd0;
                    nextState = RUN;
                end else begin
                    stallIf  = 1'b1;
                    stallId  = 1'b1;
                    bubbleEx = 1'b1;
                    nextCnt  = hazCnt - 2'd1;
                    if (hazCnt <= 2'd1) nextState = RUN;
                end
            end
            MEM_WAIT: begin
                if (hz.trap)         nextPendTrap   = 1'b1;
                if (hz.branch_taken) nextPendBranch = 1'b1;
                if (hz.mem_ack) begin
                    nextState = RUN;
                end else begin
                    stallIf  = 1'b1;
                    stallId  = 1'b1;
                    stallEx  = 1'b1;
                    stallMem = 1'b1;
                    bubbleWb = 1'b1;
                end
            end
            MDU_WAIT: begin
                if (hz.trap)         nextPendTrap   = 1'b1;
                if (hz.branch_taken) nextPendBranch = 1'b1;
                if (!hz.mdu_busy) begin
                    nextState = RUN;
                end else begin
                    stallIf   = 1'b1;
                    stallId   = 1'b1;
                    stallEx   = 1'b1;
                    bubbleMem = 1'b1;
                end
            end
            default: nextState = RUN;
        endcase
    end

    // Outputs are combinational from inputs, so gate them with reset_n to
    // keep them low for the whole time reset is asserted.
    assign hz.stall_if   = reset_n & stallIf;
    assign hz.stall_id   = reset_n & stallId;
    assign hz.stall_ex   = reset_n & stallEx;
    assign hz.stall_mem  = reset_n & stallMem;
    assign hz.bubble_ex  = reset_n & bubbleEx;
    assign hz.bubble_mem = reset_n & bubbleMem;
    assign hz.bubble_wb  = reset_n & bubbleWb;
    assign hz.flush_id   = reset_n & flushId;
    assign hz.flush_ex   = reset_n & flushEx;
    assign hz.flush_mem  = reset_n & flushMem;
    assign hz.dbgState   = state;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hz.stall_cycles <= '0;
        end else if (hz.clear_stats) begin
            hz.stall_cycles <= '0;
        end else if (stallIf && (hz.stall_cycles != '1)) begin
            hz.stall_cycles <= hz.stall_cycles + 1'b1;
        end
    end
endmodule

// File: tb/tb_hazard_sequencer.sv
module tb_hazard_sequencer;
    localparam int CW = 4;

    // Output vector order: stall_if, stall_id, stall_ex, stall_mem,
    // bubble_ex, bubble_mem, bubble_wb, flush_id, flush_ex, flush_mem
    localparam logic [9:0] O_NONE = 10'b0000000000;
    localparam logic [9:0] O_HAZ  = 10'b1100100000;
    localparam logic [9:0] O_MEM  = 10'b1111001000;
    localparam logic [9:0] O_MDU  = 10'b1110010000;
    localparam logic [9:0] O_BR   = 10'b0000000110;
    localparam logic [9:0] O_TRAP = 10'b0000000111;

    logic clock;
    logic reset_n;
    int   nChecks = 0;
    int   nFail   = 0;

    hazard_sequencer_if #(.CNT_WIDTH(CW)) hz();

    hazard_sequencer #(.CNT_WIDTH(CW)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .hz      (hz)
    );

    // ---------------- clock ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [1:0] ft;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       exWe;
        logic [4:0] exRd;
        logic       exLd;
        logic       memWe;
        logic [4:0] memRd;
        logic       memLd;
        int         n;
    } vec_t;

    vec_t vecs[11];

    function automatic logic [9:0] outs();
        return {hz.stall_if, hz.stall_id, hz.stall_ex, hz.stall_mem,
                hz.bubble_ex, hz.bubble_mem, hz.bubble_wb,
                hz.flush_id, hz.flush_ex, hz.flush_mem};
    endfunction

    task automatic chkOuts(input string name, input logic [9:0] exp);
        logic [9:0] got;
        got = outs();
        nChecks++;
        if (got !== exp) begin
            nFail++;
            $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
        end
    endtask

    task automatic chkVal(input string name, input int got, input int exp);
        nChecks++;
        if (got != exp) begin
            nFail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle();
        hz.id_rs1 = 5'd0; hz.id_rs2 = 5'd0; hz.id_fwd_type = 2'd0;
        hz.ex_reg_we = 1'b0; hz.ex_rd = 5'd0; hz.ex_mem_read = 1'b0;
        hz.mem_reg_we = 1'b0; hz.mem_rd = 5'd0; hz.mem_mem_read = 1'b0;
        hz.mem_req = 1'b0; hz.mem_ack = 1'b0; hz.mdu_busy = 1'b0;
        hz.branch_taken = 1'b0; hz.trap = 1'b0; hz.clear_stats = 1'b0;
    endtask

    task automatic applyVec(input vec_t v);
        hz.id_fwd_type = v.ft; hz.id_rs1 = v.rs1; hz.id_rs2 = v.rs2;
        hz.ex_reg_we = v.exWe; hz.ex_rd = v.exRd; hz.ex_mem_read = v.exLd;
        hz.mem_reg_we = v.memWe; hz.mem_rd = v.memRd; hz.mem_mem_read = v.memLd;
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic clearStats();
        hz.clear_stats = 1'b1;
        step();
        hz.clear_stats = 1'b0;
    endtask

    initial begin
        // ft, rs1, rs2, exWe, exRd, exLd, memWe, memRd, memLd, n
        vecs[0]  = '{2'd2, 5'd5, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0, 5'd0, 1'b0, 1};  // load-use, EX consumer
        vecs[1]  = '{2'd1, 5'd7, 5'd0, 1'b1, 5'd7, 1'b1, 1'b0, 5'd0, 1'b0, 2};  // beq on EX load
        vecs[2]  = '{2'd3, 5'd1, 5'd3, 1'b1, 5'd3, 1'b0, 1'b0, 5'd0, 1'b0, 0};  // Type1_3 rs2 on writer
        vecs[3]  = '{2'd3, 5'd3, 5'd1, 1'b1, 5'd3, 1'b0, 1'b0, 5'd0, 1'b0, 1};  // Type1_3 rs1 on writer
        vecs[4]  = '{2'd3, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 0};  // x0 never matches
        vecs[5]  = '{2'd1, 5'd4, 5'd2, 1'b0, 5'd0, 1'b0, 1'b1, 5'd4, 1'b1, 1};  // ID op on MEM load
        vecs[6]  = '{2'd2, 5'd4, 5'd2, 1'b0, 5'd0, 1'b0, 1'b1, 5'd4, 1'b1, 0};  // EX op on MEM load
        vecs[7]  = '{2'd0, 5'd5, 5'd5, 1'b1, 5'd5, 1'b1, 1'b0, 5'd0, 1'b0, 0};  // NoType
        vecs[8]  = '{2'd3, 5'd1, 5'd6, 1'b1, 5'd6, 1'b1, 1'b0, 5'd0, 1'b0, 1};  // Type1_3 rs2 on EX load
        vecs[9]  = '{2'd1, 5'd9, 5'd9, 1'b1, 5'd9, 1'b1, 1'b1, 5'd9, 1'b1, 2};  // max of 2 and 1
        vecs[10] = '{2'd2, 5'd5, 5'd0, 1'b1, 5'd5, 1'b0, 1'b0, 5'd0, 1'b0, 0};  // forwarded EX writer

        idle();
        reset_n = 1'b0;
        #2;
        chkOuts("reset_outs", O_NONE);
        chkVal("reset_cnt", int'(hz.stall_cycles), 0);
        chkVal("reset_state", int'(hz.dbgState), 0);
        @(negedge clock);
        reset_n = 1'b1;
        step();

        // ---------------- table-driven data hazards ----------------
        for (int i = 0; i < 11; i++) begin
            clearStats();
            applyVec(vecs[i]);
            for (int k = 0; k < 4; k++) begin
                @(negedge clock);
                chkOuts($sformatf("vec%0d_cyc%0d", i, k), (k < vecs[i].n) ? O_HAZ : O_NONE);
                if (vecs[i].n == 2 && k == 1)
                    chkVal($sformatf("vec%0d_state", i), int'(hz.dbgState), 1);
                step();
                if (k == 0) idle();
            end
            chkVal($sformatf("vec%0d_stall_cycles", i), int'(hz.stall_cycles), vecs[i].n);
        end

        // ---------------- trap cancels a 2-cycle hazard stall ----------------
        clearStats();
        applyVec(vecs[1]);
        @(negedge clock);
        chkOuts("cancel_c1", O_HAZ);
        step();
        idle();
        hz.trap = 1'b1;
        @(negedge clock);
        chkVal("cancel_state_haz", int'(hz.dbgState), 1);
        chkOuts("cancel_trap", O_TRAP);
        step();
        hz.trap = 1'b0;
        @(negedge clock);
        chkOuts("cancel_after", O_NONE);
        chkVal("cancel_state_run", int'(hz.dbgState), 0);
        chkVal("cancel_cnt", int'(hz.stall_cycles), 1);
        step();

        // ---------------- memory wait with branch latched ----------------
        clearStats();
        hz.mem_req = 1'b1;
        for (int k = 0; k < 4; k++) begin
            hz.branch_taken = (k == 1);
            @(negedge clock);
            chkOuts($sformatf("memwait_c%0d", k), O_MEM);
            if (k == 1) chkVal("memwait_state", int'(hz.dbgState), 2);
            step();
        end
        hz.branch_taken = 1'b0;
        hz.mem_ack = 1'b1;
        @(negedge clock);
        chkOuts("memwait_ack", O_NONE);
        step();
        hz.mem_req = 1'b0;
        hz.mem_ack = 1'b0;
        @(negedge clock);
        chkOuts("memwait_flush", O_BR);
        chkVal("memwait_cnt", int'(hz.stall_cycles), 4);
        step();
        @(negedge clock);
        chkOuts("memwait_done", O_NONE);
        step();

        // ---------------- MDU wait, saturation, clear, latched trap ----------------
        clearStats();
        hz.mdu_busy = 1'b1;
        @(negedge clock);
        chkOuts("mdu_first", O_MDU);
        for (int k = 0; k < 20; k++) step();
        chkVal("cnt_saturate", int'(hz.stall_cycles), 15);
        hz.clear_stats = 1'b1;
        step();
        chkVal("cnt_clear_in_stall", int'(hz.stall_cycles), 0);
        hz.clear_stats = 1'b0;
        step();
        chkVal("cnt_resume", int'(hz.stall_cycles), 1);
        hz.trap = 1'b1;
        @(negedge clock);
        chkOuts("mdu_trap_latched", O_MDU);
        step();
        hz.trap = 1'b0;
        hz.mdu_busy = 1'b0;
        @(negedge clock);
        chkOuts("mdu_release", O_NONE);
        step();
        @(negedge clock);
        chkOuts("mdu_pending_trap", O_TRAP);
        step();
        @(negedge clock);
        chkOuts("mdu_after_flush", O_NONE);
        step();

        // ---------------- async reset in the middle of MDU_WAIT ----------------
        hz.mdu_busy = 1'b1;
        step();
        step();
        chkVal("mdu_state_before_rst", int'(hz.dbgState), 3);
        chkOuts("mdu_outs_before_rst", O_MDU);
        #2;
        reset_n = 1'b0;
        #1;
        chkOuts("async_rst_outs", O_NONE);
        chkVal("async_rst_state", int'(hz.dbgState), 0);
        chkVal("async_rst_cnt", int'(hz.stall_cycles), 0);
        hz.mdu_busy = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        step();
        @(negedge clock);
        chkOuts("post_rst_idle", O_NONE);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end
endmodule
